fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the 16-bit core: holds the program counter, issues one-at-a-time requests to instruction memory, and presents the fetched instruction to the decode/control stage. The instruction is pre-split into op/func/register/immediate fields, and the control decoder consumes op and func directly. The stage supports downstream stall, branch/jump redirect with discard of in-flight responses, and a one-entry buffer for responses that arrive while decode is stalled.

## Interface
- XLEN, 16, datapath and PC width
- RESET_PC, 16'h0000, PC value loaded on reset (word address)
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  XLEN  word address, valid while imem_req=1
- imem_rvalid  in  1  response valid, ≥1 cycle after its request
- imem_rdata  in  16  instruction word, valid with imem_rvalid
- stall  in  1  decode cannot accept; hold id_* outputs
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  XLEN  target word address
- id_valid  out  1  id_* holds a valid instruction
- id_pc  out  XLEN  address of id_instr
- id_instr  out  16  raw instruction
- id_op  out  3  id_instr[15:13]
- id_func  out  3  id_instr[12:10]
- id_rd  out  3  id_instr[9:7]
- id_rs1  out  3  id_instr[6:4]
- id_rs2  out  3  id_instr[3:1]
- id_imm  out  XLEN  op 001/010/011/100: sext(instr[3:0]); op 101/110: sext(instr[6:0]); else 0

## Operation
- States: ISSUE, WAIT, FULL. Extra registers: pc, drop flag, buffer (instr + pc).
- Reset: state=ISSUE, pc=RESET_PC, drop=0, id_valid=0, every id_* field 0, buffer cleared. Memory is reset by the same rst; no request is outstanding across reset.
- ISSUE: imem_req=1, imem_addr=pc (Moore outputs). Next state is WAIT.
- WAIT: imem_req=0.
  - On imem_rvalid with drop=1: clear drop, go to ISSUE.
  - On imem_rvalid with drop=0 and the output register free (id_valid=0 or stall=0): load the id_* registers from imem_rdata with id_pc=pc, set pc=pc+1 (wraps 16'hFFFF to 16'h0000), go to ISSUE.
  - On imem_rvalid with drop=0, id_valid=1 and stall=1: write to the buffer, go to FULL.
- FULL: when stall=0, move the buffer to id_*, set pc=pc+1, go to ISSUE. Otherwise hold.
- Consumption: an instruction is taken when id_valid=1 and stall=0. If no new instruction loads in that cycle, id_valid clears next cycle. When stall=1, every id_* output holds.
- Redirect (highest priority, applies regardless of stall):
  - Always: pc=redirect_pc and id_valid=0 next cycle.
  - In ISSUE: the issuing request is stale, so set drop=1 and go to WAIT.
  - In WAIT without rvalid: set drop=1 and stay in WAIT. A second redirect keeps drop=1 and updates pc again.
  - In WAIT with rvalid in the same cycle: discard the response, leave drop unchanged (drop=0 after a response), go to ISSUE.
  - In FULL: discard the buffer, go to ISSUE.
- imem_rvalid outside WAIT is a protocol error and is ignored.
- Field extraction is combinational from id_instr, or registered with it; either is valid if the values match id_instr in the same cycle.

## Timing
- Best-case throughput with 1-cycle memory: one instruction every 2 cycles. Cycle N has the ISSUE pulse, cycle N+1 has the response, cycle N+2 has id_valid=1 and the next ISSUE.
- Response-to-id_valid latency: 1 cycle (registered).
- Redirect-to-first-request: 1 cycle if no response is outstanding. Otherwise 1 cycle after the dropped response arrives.
- id_* never changes while id_valid=1 and stall=1, except on redirect, which forces id_valid=0.

## Test plan
- Reset, 1-cycle memory returning addr^16'hA5A5: requests go to 0,1,2 on alternate cycles. id_pc sequence is 0,1,2 and id_instr matches. Decode check for instr 16'h2C93: id_op=001, id_func=011, id_rd=001, id_rs1=001, id_rs2=001, id_imm=16'h0003.
- Hold stall=1 for 5 cycles with an instruction valid: id_* stays unchanged, the next response goes to the buffer (state FULL), and no imem_req is issued. Release stall: the buffered instruction appears next cycle, then a request to pc+1 follows.
- redirect_valid with redirect_pc=16'h0040 while WAIT on a 3-cycle memory: the stale response is dropped, id_valid stays 0, the next imem_addr is 16'h0040, and the first delivered id_pc is 16'h0040.
- Redirect in the same cycle as imem_rvalid: the response is discarded and the request to redirect_pc is issued the next cycle. Redirect in FULL: the buffer is discarded.
- PC wrap: RESET_PC=16'hFFFF gives requests to 16'hFFFF, then 16'h0000.
- Assert rst for 1 cycle mid-WAIT: the next cycle has id_valid=0, state ISSUE, and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the 16-bit core.
//
// Holds the program counter, issues one request at a time to instruction
// memory and registers the returned word for the decode/control stage. The
// instruction is also split into op/func/register/immediate fields.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   imem_req/addr      one-cycle request pulse with its word address
//   imem_rvalid/rdata  response from instruction memory
//   stall              decode cannot accept; id_* outputs hold
//   redirect_valid/pc  taken branch/jump and its target word address
//   id_valid, id_pc    instruction valid flag and its address
//   id_instr           raw instruction word
//   id_op .. id_imm    decoded fields of id_instr
module fetch_stage #(
  parameter int              XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [15:0]     id_instr,
  output logic [2:0]      id_op,
  output logic [2:0]      id_func,
  output logic [2:0]      id_rd,
  output logic [2:0]      id_rs1,
  output logic [2:0]      id_rs2,
  output logic [XLEN-1:0] id_imm
);

  typedef enum logic [1:0] {ISSUE, WAIT, FULL} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            drop_reg, drop_next;
  logic [15:0]     buf_instr_reg, buf_instr_next;
  logic [XLEN-1:0] buf_pc_reg, buf_pc_next;
  logic            id_valid_reg, id_valid_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic [15:0]     id_instr_reg, id_instr_next;

  // The output register can take a new word when it is empty or its
  // current instruction is being consumed this cycle.
  logic out_free;
  assign out_free = !id_valid_reg || !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ISSUE;
      pc_reg        <= RESET_PC;
      drop_reg      <= 1'b0;
      buf_instr_reg <= '0;
      buf_pc_reg    <= '0;
      id_valid_reg  <= 1'b0;
      id_pc_reg     <= '0;
      id_instr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_reg      <= drop_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
      id_valid_reg  <= id_valid_next;
      id_pc_reg     <= id_pc_next;
      id_instr_reg  <= id_instr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_next      = drop_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    id_valid_next  = id_valid_reg;
    id_pc_next     = id_pc_reg;
    id_instr_next  = id_instr_reg;
    imem_req       = 1'b0;
    imem_addr      = pc_reg;

    // Consumed instruction leaves unless something new loads below.
    if (id_valid_reg && !stall) begin
      id_valid_next = 1'b0;
    end

    case (state_reg)
      ISSUE: begin
        imem_req   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_reg) begin
            drop_next  = 1'b0;
            state_next = ISSUE;
          end else if (out_free) begin
            id_valid_next = 1'b1;
            id_pc_next    = pc_reg;
            id_instr_next = imem_rdata;
            pc_next       = pc_reg + XLEN'(1);
            state_next    = ISSUE;
          end else begin
            buf_instr_next = imem_rdata;
            buf_pc_next    = pc_reg;
            state_next     = FULL;
          end
        end
      end
      FULL: begin
        if (!stall) begin
          id_valid_next = 1'b1;
          id_pc_next    = buf_pc_reg;
          id_instr_next = buf_instr_reg;
          pc_next       = pc_reg + XLEN'(1);
          state_next    = ISSUE;
        end
      end
      default: state_next = ISSUE;
    endcase

    // Redirect overrides everything above. The visible id_* fields are
    // kept as they were; only id_valid is cleared.
    if (redirect_valid) begin
      pc_next        = redirect_pc;
      id_valid_next  = 1'b0;
      id_pc_next     = id_pc_reg;
      id_instr_next  = id_instr_reg;
      buf_instr_next = buf_instr_reg;
      buf_pc_next    = buf_pc_reg;
      case (state_reg)
        ISSUE: begin
          drop_next  = 1'b1;
          state_next = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            // The arriving response is discarded; nothing is outstanding
            // afterwards, so the drop flag must end up clear.
            drop_next  = 1'b0;
            state_next = ISSUE;
          end else begin
            drop_next  = 1'b1;
            state_next = WAIT;
          end
        end
        default: begin
          drop_next  = 1'b0;
          state_next = ISSUE;
        end
      endcase
    end
  end

  // Field extraction straight from the output register.
  logic [XLEN-1:0] imm4, imm7;

  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_sext
      assign imm4[gi] = id_instr_reg[(gi < 4) ? gi : 3];
      assign imm7[gi] = id_instr_reg[(gi < 7) ? gi : 6];
    end
  endgenerate

  always_comb begin
    id_imm = '0;
    case (id_instr_reg[15:13])
      3'b001, 3'b010, 3'b011, 3'b100: id_imm = imm4;
      3'b101, 3'b110:                 id_imm = imm7;
      default:                        id_imm = '0;
    endcase
  end

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_instr = id_instr_reg;
  assign id_op    = id_instr_reg[15:13];
  assign id_func  = id_instr_reg[12:10];
  assign id_rd    = id_instr_reg[9:7];
  assign id_rs1   = id_instr_reg[6:4];
  assign id_rs2   = id_instr_reg[3:1];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] imem_rdata_w;

  logic        imem_req, id_valid;
  logic [15:0] imem_addr, id_pc, id_instr, id_imm;
  logic [2:0]  id_op, id_func, id_rd, id_rs1, id_rs2;

  logic        imem_req_w, id_valid_w;
  logic [15:0] imem_addr_w, id_pc_w, id_instr_w, id_imm_w;
  logic [2:0]  id_op_w, id_func_w, id_rd_w, id_rs1_w, id_rs2_w;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_op(id_op), .id_func(id_func), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm)
  );

  // Second instance for the PC wrap case; it sees the same control inputs,
  // so its request timing tracks the first instance exactly.
  fetch_stage #(.XLEN(16), .RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata_w),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid_w), .id_pc(id_pc_w), .id_instr(id_instr_w),
    .id_op(id_op_w), .id_func(id_func_w), .id_rd(id_rd_w),
    .id_rs1(id_rs1_w), .id_rs2(id_rs2_w), .id_imm(id_imm_w)
  );

  // Instruction memory model: word at address a is a ^ mem_key, returned
  // mem_lat cycles after the request cycle.
  int          mem_lat = 1;
  logic [15:0] mem_key = 16'hA5A5;
  logic        mem_pend;
  int          mem_cnt;
  logic [15:0] mem_addr, mem_addr_w;

  always @(posedge clk) begin
    if (rst) begin
      mem_pend     <= 1'b0;
      mem_cnt      <= 0;
      imem_rvalid  <= 1'b0;
      imem_rdata   <= '0;
      imem_rdata_w <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_rvalid  <= 1'b1;
          imem_rdata   <= imem_addr ^ mem_key;
          imem_rdata_w <= imem_addr_w ^ mem_key;
        end else begin
          mem_pend   <= 1'b1;
          mem_cnt    <= mem_lat - 1;
          mem_addr   <= imem_addr;
          mem_addr_w <= imem_addr_w;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 1) begin
          imem_rvalid  <= 1'b1;
          imem_rdata   <= mem_addr ^ mem_key;
          imem_rdata_w <= mem_addr_w ^ mem_key;
          mem_pend     <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  // Reference immediate, computed arithmetically from the field rules.
  function automatic logic [15:0] ref_imm(input logic [15:0] ins);
    int v;
    int op;
    op = int'(ins[15:13]);
    v = 0;
    if (op >= 1 && op <= 4) begin
      v = int'(ins[3:0]);
      if (v > 7) v = v - 16;
    end else if (op == 5 || op == 6) begin
      v = int'(ins[6:0]);
      if (v > 63) v = v - 128;
    end
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench #1 after the reset edge with rst released: cycle 0.
  task automatic do_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    tests_run++;
    if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    tests_run++;
    if (id_pc !== 16'h0000 || id_instr !== 16'h0000 || id_imm !== 16'h0000 || id_op !== 3'd0)
      begin tests_failed++; $display("FAIL reset_fields pc=%h instr=%h imm=%h op=%0d exp all 0", id_pc, id_instr, id_imm, id_op); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic even, exp_v;
    logic [15:0] idx;
    mem_lat = 1;
    mem_key = 16'hA5A5;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      even = (c % 2 == 0);
      idx = 16'(c / 2);
      tests_run++;
      if (imem_req !== even) begin tests_failed++; $display("FAIL seq_req c=%0d got=%b exp=%b", c, imem_req, even); end
      if (even) begin
        tests_run++;
        if (imem_addr !== idx) begin tests_failed++; $display("FAIL seq_addr c=%0d got=%h exp=%h", c, imem_addr, idx); end
      end
      exp_v = even && (c >= 2);
      tests_run++;
      if (id_valid !== exp_v) begin tests_failed++; $display("FAIL seq_valid c=%0d got=%b exp=%b", c, id_valid, exp_v); end
      if (exp_v) begin
        tests_run++;
        if (id_pc !== idx - 16'd1 || id_instr !== ((idx - 16'd1) ^ 16'hA5A5))
          begin tests_failed++; $display("FAIL seq_data c=%0d pc=%h instr=%h exp pc=%h instr=%h", c, id_pc, id_instr, idx - 16'd1, (idx - 16'd1) ^ 16'hA5A5); end
        $display("[TB] seq delivered pc=%h instr=%h", id_pc, id_instr);
      end
      tick();
    end
  endtask

  task automatic test_decode();
    logic [15:0] keys [3];
    logic [2:0]  e_op [3];
    logic [2:0]  e_func [3];
    logic [2:0]  e_rd [3];
    logic [2:0]  e_rs1 [3];
    logic [2:0]  e_rs2 [3];
    logic [15:0] e_imm [3];
    keys   = '{16'h2C93, 16'hA07F, 16'h0FFF};
    e_op   = '{3'd1, 3'd5, 3'd0};
    e_func = '{3'd3, 3'd0, 3'd3};
    e_rd   = '{3'd1, 3'd0, 3'd7};
    e_rs1  = '{3'd1, 3'd7, 3'd7};
    e_rs2  = '{3'd1, 3'd7, 3'd7};
    e_imm  = '{16'h0003, 16'hFFFF, 16'h0000};
    mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      mem_key = keys[i];
      do_reset();
      tick();
      tick();
      tests_run++;
      if (id_valid !== 1'b1 || id_instr !== keys[i])
        begin tests_failed++; $display("FAIL dec_instr i=%0d valid=%b instr=%h exp %h", i, id_valid, id_instr, keys[i]); end
      tests_run++;
      if (id_op !== e_op[i] || id_func !== e_func[i] || id_rd !== e_rd[i] || id_rs1 !== e_rs1[i] || id_rs2 !== e_rs2[i])
        begin tests_failed++; $display("FAIL dec_fields i=%0d got %0d/%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d/%0d", i,
          id_op, id_func, id_rd, id_rs1, id_rs2, e_op[i], e_func[i], e_rd[i], e_rs1[i], e_rs2[i]); end
      tests_run++;
      if (id_imm !== e_imm[i]) begin tests_failed++; $display("FAIL dec_imm i=%0d got=%h exp=%h", i, id_imm, e_imm[i]); end
    end
  endtask

  task automatic test_stall();
    mem_lat = 1;
    mem_key = 16'hA5A5;
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      tests_run++;
      if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_instr !== 16'hA5A5)
        begin tests_failed++; $display("FAIL stall_hold c=%0d valid=%b pc=%h instr=%h exp 1/0000/a5a5", c, id_valid, id_pc, id_instr); end
      if (c >= 3) begin
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_noreq c=%0d got=%b exp=0", c, imem_req); end
      end
      tick();
    end
    stall = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0 || id_pc !== 16'h0000) begin tests_failed++; $display("FAIL stall_release req=%b pc=%h exp 0/0000", imem_req, id_pc); end
    tick();
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0001 || id_instr !== (16'h0001 ^ 16'hA5A5))
      begin tests_failed++; $display("FAIL stall_buf valid=%b pc=%h instr=%h exp 1/0001/%h", id_valid, id_pc, id_instr, 16'h0001 ^ 16'hA5A5); end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002)
      begin tests_failed++; $display("FAIL stall_nextreq req=%b addr=%h exp 1/0002", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    int n;
    mem_lat = 3;
    mem_key = 16'hA5A5;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      tests_run++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0)
        begin tests_failed++; $display("FAIL rdw_quiet c=%0d req=%b valid=%b exp 0/0", c, imem_req, id_valid); end
      tick();
    end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || id_valid !== 1'b0)
      begin tests_failed++; $display("FAIL rdw_req req=%b addr=%h valid=%b exp 1/0040/0", imem_req, imem_addr, id_valid); end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0040 || id_instr !== (16'h0040 ^ 16'hA5A5))
      begin tests_failed++; $display("FAIL rdw_first valid=%b pc=%h instr=%h exp 1/0040/%h", id_valid, id_pc, id_instr, 16'h0040 ^ 16'hA5A5); end
  endtask

  task automatic test_redirect_rvalid();
    int n;
    mem_lat = 1;
    mem_key = 16'hA5A5;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0123;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0123 || id_valid !== 1'b0)
      begin tests_failed++; $display("FAIL rdr_req req=%b addr=%h valid=%b exp 1/0123/0", imem_req, imem_addr, id_valid); end
    tick();
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL rdr_discard valid=%b exp=0", id_valid); end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0123)
      begin tests_failed++; $display("FAIL rdr_first valid=%b pc=%h exp 1/0123", id_valid, id_pc); end
  endtask

  task automatic test_redirect_full();
    int n;
    mem_lat = 1;
    mem_key = 16'hA5A5;
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0200)
      begin tests_failed++; $display("FAIL rdf_req valid=%b req=%b addr=%h exp 0/1/0200", id_valid, imem_req, imem_addr); end
    stall = 1'b0;
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0200 || id_instr !== (16'h0200 ^ 16'hA5A5))
      begin tests_failed++; $display("FAIL rdf_first valid=%b pc=%h instr=%h exp 1/0200/%h", id_valid, id_pc, id_instr, 16'h0200 ^ 16'hA5A5); end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    mem_key = 16'h1234;
    do_reset();
    tests_run++;
    if (imem_req_w !== 1'b1 || imem_addr_w !== 16'hFFFF)
      begin tests_failed++; $display("FAIL wrap_req0 req=%b addr=%h exp 1/ffff", imem_req_w, imem_addr_w); end
    tick();
    tick();
    tests_run++;
    if (imem_req_w !== 1'b1 || imem_addr_w !== 16'h0000)
      begin tests_failed++; $display("FAIL wrap_req1 req=%b addr=%h exp 1/0000", imem_req_w, imem_addr_w); end
    tests_run++;
    if (id_valid_w !== 1'b1 || id_pc_w !== 16'hFFFF || id_instr_w !== (16'hFFFF ^ 16'h1234))
      begin tests_failed++; $display("FAIL wrap_id0 valid=%b pc=%h instr=%h exp 1/ffff/%h", id_valid_w, id_pc_w, id_instr_w, 16'hFFFF ^ 16'h1234); end
    tick();
    tick();
    tests_run++;
    if (id_valid_w !== 1'b1 || id_pc_w !== 16'h0000 || id_imm_w !== ref_imm(id_instr_w) || id_op_w !== 3'd0)
      begin tests_failed++; $display("FAIL wrap_id1 valid=%b pc=%h imm=%h op=%0d exp 1/0000/%h/0", id_valid_w, id_pc_w, id_imm_w, id_op_w, ref_imm(id_instr_w)); end
  endtask

  task automatic test_rst_midwait();
    int n;
    mem_lat = 3;
    mem_key = 16'hA5A5;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000 || id_pc !== 16'h0000)
      begin tests_failed++; $display("FAIL rstw_state valid=%b req=%b addr=%h pc=%h exp 0/1/0000/0000", id_valid, imem_req, imem_addr, id_pc); end
    rst = 1'b0;
    stall = 1'b0;
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0000)
      begin tests_failed++; $display("FAIL rstw_first valid=%b pc=%h exp 1/0000", id_valid, id_pc); end
  endtask

  // Random stall/redirect traffic. The model only knows the delivery rule:
  // instructions appear in address order from the reset PC or from the most
  // recent redirect target, each word equal to its address ^ key.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic        prev_hold, prev_redir;
    int          delivered;
    for (int trial = 0; trial < 6; trial++) begin
      mem_lat = $urandom_range(1, 4);
      mem_key = 16'($urandom);
      do_reset();
      exp_pc = 16'h0000;
      prev_hold = 1'b0;
      prev_redir = 1'b0;
      delivered = 0;
      for (int c = 0; c < 200; c++) begin
        tests_run++;
        if (imem_req === 1'b1 && (mem_pend || imem_rvalid))
          begin tests_failed++; $display("FAIL rnd_overlap t=%0d c=%0d req while outstanding", trial, c); end
        if (prev_redir) begin
          tests_run++;
          if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL rnd_redir_valid t=%0d c=%0d got=%b exp=0", trial, c, id_valid); end
        end else if (prev_hold) begin
          tests_run++;
          if (id_valid !== 1'b1) begin tests_failed++; $display("FAIL rnd_hold t=%0d c=%0d got=%b exp=1", trial, c, id_valid); end
        end
        if (id_valid === 1'b1) begin
          tests_run++;
          if (id_pc !== exp_pc || id_instr !== (exp_pc ^ mem_key))
            begin tests_failed++; $display("FAIL rnd_data t=%0d c=%0d pc=%h instr=%h exp %h/%h", trial, c, id_pc, id_instr, exp_pc, exp_pc ^ mem_key); end
          tests_run++;
          if (id_op !== id_instr[15:13] || id_func !== id_instr[12:10] || id_rd !== id_instr[9:7] ||
              id_rs1 !== id_instr[6:4] || id_rs2 !== id_instr[3:1] || id_imm !== ref_imm(id_instr))
            begin tests_failed++; $display("FAIL rnd_decode t=%0d c=%0d instr=%h imm=%h exp imm=%h", trial, c, id_instr, id_imm, ref_imm(id_instr)); end
        end
        stall = ($urandom_range(0, 3) == 0);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc = 16'($urandom);
        prev_hold = id_valid && stall && !redirect_valid;
        prev_redir = redirect_valid;
        if (redirect_valid) begin
          exp_pc = redirect_pc;
        end else if (id_valid === 1'b1 && !stall) begin
          exp_pc = exp_pc + 16'd1;
          delivered++;
        end
        tick();
      end
      stall = 1'b0;
      redirect_valid = 1'b0;
      tests_run++;
      if (delivered < 10) begin tests_failed++; $display("FAIL rnd_progress t=%0d delivered=%0d exp>=10", trial, delivered); end
      $display("[TB] random trial %0d lat=%0d delivered=%0d", trial, mem_lat, delivered);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_full();
    test_wrap();
    test_rst_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
